fetch_stage: RTL

// - IF stage plus IF/ID register of the 5-stage RV32I pipeline, directly upstream of the pipeline control unit.
// - Consumes select_pc/select_pc2/select_ir2 and the jump/branch targets.
// - Owns the PC, a 1-outstanding instruction-memory req/valid handshake, a 1-entry fetch buffer, and IR2/PC2.
// - Produces ir2_output/pc2_output for decode and hazard control.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 40 ++++
 rtl/fetch_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and encodings for the IF stage: FSM states, PC/IR2 select codes, bubble instruction.
package fetch_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StKill} fetch_state_e;

  localparam logic [1:0] PC_JUMP   = 2'd0;
  localparam logic [1:0] PC_SEQ    = 2'd1;
  localparam logic [1:0] PC_HOLD   = 2'd2;
  localparam logic [1:0] PC_BRANCH = 2'd3;

  localparam logic [1:0] IR2_LOAD = 2'd0;
  localparam logic [1:0] IR2_NOP  = 2'd1;
  localparam logic [1:0] IR2_HOLD = 2'd2;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry fetch buffer holding a returned instruction and the PC it was fetched from.
module fetch_buffer (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [31:0] write_inst,
  input  logic [31:0] write_pc,
  input  logic        consume,
  input  logic        flush,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;

  // Flush wins over a same-cycle write so a squashed response never lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (write) begin
      valid_q <= 1'b1;
      inst_q  <= write_inst;
      pc_q    <= write_pc;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign inst  = inst_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage with IF/ID register: PC, single-outstanding imem handshake, fetch buffer, IR2/PC2.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  select_pc,
  input  logic        select_pc2,
  input  logic [1:0]  select_ir2,
  input  logic [31:0] jump_address,
  input  logic [31:0] branch_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_output,
  output logic [31:0] ir2_output,
  output logic [31:0] pc2_output,
  output logic        fetch_stall
);
  import fetch_pkg::*;

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  tag_q;
  logic [31:0]  ir2_q;
  logic [31:0]  pc2_q;

  logic        buf_valid;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;

  logic        redirect;
  logic [31:0] target;
  logic        consume;
  logic        accept;
  logic        buf_write;

  assign redirect = (select_pc == PC_JUMP) || (select_pc == PC_BRANCH);
  assign target   = (select_pc == PC_JUMP) ? jump_address : branch_address;
  assign consume  = (select_ir2 == IR2_LOAD) && buf_valid;

  // Reset gates the combinational outputs so they drop as soon as reset asserts.
  assign imem_req = reset && (state_q == StIdle) && (select_pc == PC_SEQ) &&
                    (!buf_valid || consume);
  assign accept      = imem_req && imem_ready;
  assign buf_write   = (state_q == StWait) && imem_rvalid && !redirect;
  assign fetch_stall = reset && (select_ir2 == IR2_LOAD) && !buf_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      tag_q   <= '0;
    end else begin
      if (redirect) begin
        pc_q <= target;
      end else if (accept) begin
        pc_q <= pc_q + 32'd4;
      end
      if (accept) begin
        tag_q <= pc_q;
      end
      case (state_q)
        StIdle: if (accept) state_q <= StWait;
        // A response arriving with the redirect is complete, so no KILL is needed.
        StWait: begin
          if (imem_rvalid)   state_q <= StIdle;
          else if (redirect) state_q <= StKill;
        end
        StKill: if (imem_rvalid) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir2_q <= NOP_INST;
      pc2_q <= '0;
    end else begin
      case (select_ir2)
        IR2_LOAD: begin
          if (buf_valid) begin
            ir2_q <= buf_inst;
            if (select_pc2 == 1'b0) pc2_q <= buf_pc;
          end else begin
            ir2_q <= NOP_INST;
          end
        end
        IR2_NOP: ir2_q <= NOP_INST;
        default: ;
      endcase
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk        (clk),
    .reset      (reset),
    .write      (buf_write),
    .write_inst (imem_rdata),
    .write_pc   (tag_q),
    .consume    (consume),
    .flush      (redirect),
    .valid      (buf_valid),
    .inst       (buf_inst),
    .pc         (buf_pc)
  );

  assign imem_addr  = pc_q;
  assign pc_output  = pc_q;
  assign ir2_output = ir2_q;
  assign pc2_output = pc2_q;

endmodule
